mem_arbiter: RTL and testbench

Arbitrates the single-port unified instruction/data memory between the fetch stage (read-only) and the memory stage (read/write) of the 5-stage MIPS pipeline. Each granted request is forwarded to the memory port, and the arbiter waits for the memory handshake or a timeout. It then returns a one-cycle acknowledge with registered read data. A combinational `stall` is exported so the pipeline freezes while any request is outstanding.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch stage (read-only)
// and the memory stage (read/write). Each granted request is forwarded to the
// memory port. The arbiter waits for m_ack or a timeout, then answers with a
// one-cycle ack and registered read data. Contention alternates between the
// two ports, starting with data after reset.
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ack,
   output logic          stall,
   output logic          bus_err
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   // Final counter value before abort; m_req is then high for exactly TIMEOUT cycles.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t        state;
   state_t        state_nxt;
   logic          last_grant;   // 0 = fetch, 1 = data
   logic          gnt_data;     // port owning the current transfer (1 = data)
   logic          err;          // current transfer timed out
   logic [7:0]    cnt;
   logic          any_req;
   logic          grant_data;
   logic          timeout_hit;
   logic [DW-1:0] capture_val;

   assign any_req     = if_req | d_req;
   // Data wins when it is alone, or when both request and fetch was served last.
   assign grant_data  = d_req & (~if_req | ~last_grant);
   assign timeout_hit = (cnt == CNT_LAST);
   // Writes return zero read data.
   assign capture_val = m_we ? '0 : m_rdata;
   assign stall       = (if_req & ~if_ack) | (d_req & ~d_ack);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and ack decode; acks and bus_err are only active in RESP.
   always_comb begin
      state_nxt = state;
      if_ack    = 1'b0;
      d_ack     = 1'b0;
      bus_err   = 1'b0;
      case (state)
         IDLE: if (any_req) state_nxt = BUSY;
         BUSY: if (m_ack || timeout_hit) state_nxt = RESP;
         RESP: begin
            if_ack    = ~gnt_data;
            d_ack     = gnt_data;
            bus_err   = err;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Memory port, read data, timeout counter and arbitration history.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         cnt        <= '0;
         err        <= 1'b0;
         gnt_data   <= 1'b0;
         last_grant <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  m_req      <= 1'b1;
                  gnt_data   <= grant_data;
                  last_grant <= grant_data;
                  cnt        <= '0;
                  err        <= 1'b0;
                  if (grant_data) begin
                     m_we    <= d_we;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                  end else begin
                     m_we    <= 1'b0;
                     m_addr  <= if_addr;
                     m_wdata <= '0;
                  end
               end
            end
            BUSY: begin
               if (m_ack) begin
                  m_req <= 1'b0;
                  if (gnt_data) d_rdata  <= capture_val;
                  else          if_rdata <= capture_val;
               end else if (timeout_hit) begin
                  m_req <= 1'b0;
                  err   <= 1'b1;
                  if (gnt_data) d_rdata  <= '0;
                  else          if_rdata <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RESP: err <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter, built with TIMEOUT = 4.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;
   logic          stall;
   logic          bus_err;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack),
      .stall(stall), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({m_req, m_we, if_ack, d_ack, bus_err, stall} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 000000", {m_req, m_we, if_ack, d_ack, bus_err, stall});
      end
      checks++;
      if ({m_addr, m_wdata, if_rdata, d_rdata} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data got %h exp 0", {m_addr, m_wdata, if_rdata, d_rdata});
      end
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      // cycle 0
      if_req = 1'b1; if_addr = 32'h100; #0;
      checks++;
      if ({stall, m_req} !== 2'b10) begin
         errors++; $display("FAIL fetch_c0 stall,m_req got %b exp 10", {stall, m_req});
      end
      tick(); // cycle 1
      checks++;
      if ({stall, m_req, m_we, m_addr} !== {3'b110, 32'h100}) begin
         errors++; $display("FAIL fetch_c1 got %b %h exp 110 00000100", {stall, m_req, m_we}, m_addr);
      end
      m_ack = 1'b1; m_rdata = 32'h8C220004;
      tick(); // cycle 2
      m_ack = 1'b0;
      checks++;
      if ({if_ack, d_ack, bus_err, m_req, stall} !== 5'b10000) begin
         errors++; $display("FAIL fetch_c2_ctrl got %b exp 10000", {if_ack, d_ack, bus_err, m_req, stall});
      end
      checks++;
      if (if_rdata !== 32'h8C220004) begin
         errors++; $display("FAIL fetch_rdata got %h exp 8c220004", if_rdata);
      end
      if_req = 1'b0;
      tick(); // cycle 3
      checks++;
      if ({if_ack, if_rdata} !== {1'b0, 32'h8C220004}) begin
         errors++; $display("FAIL fetch_hold got %b %h exp 0 8c220004", if_ack, if_rdata);
      end
   endtask

   task automatic test_write();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
      m_rdata = 32'h12345678;
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++;
         if ({m_req, m_we, d_ack, m_addr, m_wdata} !== {3'b110, 32'h2000, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL write_busy_c%0d got %b %h %h exp 110 00002000 deadbeef", c, {m_req, m_we, d_ack}, m_addr, m_wdata);
         end
         if (c == 4) m_ack = 1'b1;
      end
      tick(); // cycle 5
      m_ack = 1'b0;
      checks++;
      if ({d_ack, if_ack, bus_err, m_req} !== 4'b1000) begin
         errors++; $display("FAIL write_ack got %b exp 1000", {d_ack, if_ack, bus_err, m_req});
      end
      checks++;
      if (d_rdata !== 32'h0) begin
         errors++; $display("FAIL write_rdata got %h exp 0", d_rdata);
      end
      d_req = 1'b0; d_we = 1'b0;
      tick();
   endtask

   task automatic test_arbitration();
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h400;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'hA5A5A5A5;
      tick();
      checks++;
      if ({stall, m_req} !== 2'b10) begin
         errors++; $display("FAIL arb_rst_stall got %b exp 10", {stall, m_req});
      end
      rst = 1'b0;
      tick(); // cycle 1: data granted first
      checks++;
      if ({m_req, m_we, m_addr} !== {2'b10, 32'h3000}) begin
         errors++; $display("FAIL arb_first got %b %h exp 10 00003000", {m_req, m_we}, m_addr);
      end
      m_ack = 1'b1; m_rdata = 32'h22222222;
      tick(); // cycle 2
      m_ack = 1'b0;
      checks++;
      if ({d_ack, if_ack, d_rdata, if_rdata} !== {2'b10, 32'h22222222, 32'h0}) begin
         errors++; $display("FAIL arb_first_ack got %b %h %h exp 10 22222222 0", {d_ack, if_ack}, d_rdata, if_rdata);
      end
      tick(); // cycle 3 idle
      tick(); // cycle 4: fetch granted
      checks++;
      if ({m_req, m_we, m_addr, m_wdata} !== {2'b10, 32'h400, 32'h0}) begin
         errors++; $display("FAIL arb_second got %b %h %h exp 10 00000400 0", {m_req, m_we}, m_addr, m_wdata);
      end
      m_ack = 1'b1; m_rdata = 32'h11111111;
      tick(); // cycle 5
      m_ack = 1'b0;
      checks++;
      if ({if_ack, d_ack, if_rdata, d_rdata} !== {2'b10, 32'h11111111, 32'h22222222}) begin
         errors++; $display("FAIL arb_second_ack got %b %h %h exp 10 11111111 22222222", {if_ack, d_ack}, if_rdata, d_rdata);
      end
      tick(); // cycle 6 idle
      tick(); // cycle 7: data again
      checks++;
      if ({m_req, m_addr} !== {1'b1, 32'h3000}) begin
         errors++; $display("FAIL arb_third got %b %h exp 1 00003000", m_req, m_addr);
      end
      m_ack = 1'b1; m_rdata = 32'h33333333;
      tick(); // cycle 8
      m_ack = 1'b0;
      checks++;
      if ({d_ack, d_rdata} !== {1'b1, 32'h33333333}) begin
         errors++; $display("FAIL arb_third_ack got %b %h exp 1 33333333", d_ack, d_rdata);
      end
      if_req = 1'b0; d_req = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
      m_rdata = 32'hFFFFFFFF;
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++;
         if ({m_req, d_ack, bus_err} !== 3'b100) begin
            errors++; $display("FAIL timeout_busy_c%0d got %b exp 100", c, {m_req, d_ack, bus_err});
         end
      end
      tick(); // cycle 5
      checks++;
      if ({m_req, d_ack, bus_err, d_rdata} !== {3'b011, 32'h0}) begin
         errors++; $display("FAIL timeout_ack got %b %h exp 011 0", {m_req, d_ack, bus_err}, d_rdata);
      end
      d_req = 1'b0;
      tick();
      checks++;
      if ({d_ack, bus_err} !== 2'b00) begin
         errors++; $display("FAIL timeout_clear got %b exp 00", {d_ack, bus_err});
      end
      // Next request is served normally (L = 1).
      if_req = 1'b1; if_addr = 32'h104;
      tick();
      tick();
      m_ack = 1'b1; m_rdata = 32'h0000BEEF;
      tick();
      m_ack = 1'b0;
      checks++;
      if ({if_ack, bus_err, if_rdata} !== {2'b10, 32'h0000BEEF}) begin
         errors++; $display("FAIL timeout_next got %b %h exp 10 0000beef", {if_ack, bus_err}, if_rdata);
      end
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_ack_at_limit();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000;
      tick(); tick(); tick();
      tick(); // cycle 4: last allowed cycle
      checks++;
      if (m_req !== 1'b1) begin
         errors++; $display("FAIL limit_mreq got %b exp 1", m_req);
      end
      m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
      tick();
      m_ack = 1'b0;
      checks++;
      if ({d_ack, bus_err, d_rdata} !== {2'b10, 32'hCAFEF00D}) begin
         errors++; $display("FAIL limit_ack got %b %h exp 10 cafef00d", {d_ack, bus_err}, d_rdata);
      end
      d_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_busy();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h7000; d_wdata = 32'h01020304;
      tick();
      checks++;
      if ({m_req, m_we, m_addr} !== {2'b11, 32'h7000}) begin
         errors++; $display("FAIL rstbusy_pre got %b %h exp 11 00007000", {m_req, m_we}, m_addr);
      end
      rst = 1'b1;
      d_req = 1'b0;
      tick();
      checks++;
      if ({m_req, m_we, if_ack, d_ack, bus_err, m_addr, m_wdata, if_rdata, d_rdata} !== 133'h0) begin
         errors++;
         $display("FAIL rstbusy_outs got %b %h %h %h %h exp all 0", {m_req, m_we, if_ack, d_ack, bus_err}, m_addr, m_wdata, if_rdata, d_rdata);
      end
      rst = 1'b0;
      m_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({m_req, if_ack, d_ack, bus_err} !== 4'b0) begin
            errors++; $display("FAIL rstbusy_noack_%0d got %b exp 0000", c, {m_req, if_ack, d_ack, bus_err});
         end
      end
      m_ack = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7004;
      tick();
      checks++;
      if ({m_req, m_addr} !== {1'b1, 32'h7004}) begin
         errors++; $display("FAIL rstbusy_after_req got %b %h exp 1 00007004", m_req, m_addr);
      end
      m_ack = 1'b1; m_rdata = 32'h0BADF00D;
      tick();
      m_ack = 1'b0;
      checks++;
      if ({d_ack, bus_err, d_rdata} !== {2'b10, 32'h0BADF00D}) begin
         errors++; $display("FAIL rstbusy_after_ack got %b %h exp 10 0badf00d", {d_ack, bus_err}, d_rdata);
      end
      d_req = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      m_rdata = '0; m_ack = 1'b0;
      test_reset();
      tick();
      test_fetch();
      test_write();
      test_arbitration();
      test_timeout();
      test_ack_at_limit();
      test_reset_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
